// File: rtl/rvx_pipe_pkg.sv
// rvx_pipe_pkg: shared types and constants for the RVX10-P hazard controller.
package rvx_pipe_pkg;
  typedef enum logic [1:0] {FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10} fwd_sel_t;
  typedef enum logic [1:0] {RUN = 2'b00, MEM_WAIT = 2'b01, FAULT = 2'b10} mem_fsm_t;
  localparam logic [4:0] REG_X0 = 5'd0;
endpackage

// File: rtl/fwd_unit.sv
// fwd_unit: EX-operand forwarding select for one source register (MEM beats WB, x0 never forwarded).
module fwd_unit
  import rvx_pipe_pkg::*;
(
  input  logic [4:0] i_rs,
  input  logic [4:0] i_rd_m,
  input  logic [4:0] i_rd_w,
  input  logic       i_wr_m,
  input  logic       i_wr_w,
  output logic [1:0] o_sel
);
  logic w_hit_m, w_hit_w;
  assign w_hit_m = i_wr_m && i_rd_m != REG_X0 && i_rd_m == i_rs;
  assign w_hit_w = i_wr_w && i_rd_w != REG_X0 && i_rd_w == i_rs;
  assign o_sel   = w_hit_m ? FWD_MEM : w_hit_w ? FWD_WB : FWD_RF;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/forwarding and data-memory wait sequencing for the 5-stage pipeline.
// Optional perf counters (CycleCnt/RetireCnt/StallCnt) when PIPE_PERF_CNT_EN is defined.
module pipe_hazard_ctrl
  import rvx_pipe_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             validE,
  input  logic             validM,
  input  logic             validW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             ResultSrcE0,
  input  logic             PCSrcE,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             ValidMtoW,
  output logic             MemFault
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] CycleCnt,
  output logic [CNT_W-1:0] RetireCnt,
  output logic [CNT_W-1:0] StallCnt
`endif
);
  mem_fsm_t         r_state, w_next;
  logic [CNT_W-1:0] r_wcnt, w_wcnt_next;
  logic             w_wr_m, w_wr_w, w_lw_stall;

  assign w_wr_m     = validM & RegWriteM;
  assign w_wr_w     = validW & RegWriteW;
  assign w_lw_stall = validE & ResultSrcE0 & (RdE != REG_X0) & (RdE == Rs1D | RdE == Rs2D);
  assign MemFault   = r_state == FAULT;

  fwd_unit u_fwd_a (
    .i_rs  (Rs1E),
    .i_rd_m(RdM),
    .i_rd_w(RdW),
    .i_wr_m(w_wr_m),
    .i_wr_w(w_wr_w),
    .o_sel (ForwardAE)
  );

  fwd_unit u_fwd_b (
    .i_rs  (Rs2E),
    .i_rd_m(RdM),
    .i_rd_w(RdW),
    .i_wr_m(w_wr_m),
    .i_wr_w(w_wr_w),
    .o_sel (ForwardBE)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= RUN;
      r_wcnt  <= '0;
    end else begin
      r_state <= w_next;
      r_wcnt  <= w_wcnt_next;
    end
  end

  // During a memory wait the whole pipe holds; holding wins over any flush request.
  always_comb begin
    w_next      = r_state;
    w_wcnt_next = r_wcnt;
    StallF      = 1'b0;
    StallD      = 1'b0;
    StallE      = 1'b0;
    StallM      = 1'b0;
    FlushD      = 1'b0;
    FlushE      = 1'b0;
    ValidMtoW   = 1'b0;
    if (reset) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else begin
      case (r_state)
        RUN: begin
          StallF    = w_lw_stall;
          StallD    = w_lw_stall;
          FlushE    = w_lw_stall | PCSrcE;
          FlushD    = PCSrcE;
          ValidMtoW = validM;
          if (validM & MemReqM & ~MemReadyM) begin
            w_next      = MEM_WAIT;
            w_wcnt_next = CNT_W'(1);
          end
        end
        MEM_WAIT: begin
          if (MemReadyM) begin
            w_next      = RUN;
            w_wcnt_next = '0;
            ValidMtoW   = 1'b1;
          end else begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            if (r_wcnt == CNT_W'(MEM_TIMEOUT)) w_next = FAULT;
            else w_wcnt_next = r_wcnt + CNT_W'(1);
          end
        end
        FAULT: begin
          StallF = 1'b1;
          StallD = 1'b1;
          StallE = 1'b1;
          StallM = 1'b1;
        end
        default: w_next = RUN;
      endcase
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] r_cycle_cnt, r_retire_cnt, r_stall_cnt;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cycle_cnt  <= '0;
      r_retire_cnt <= '0;
      r_stall_cnt  <= '0;
    end else begin
      r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
      if (validW) r_retire_cnt <= r_retire_cnt + CNT_W'(1);
      if (StallF) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end
  assign CycleCnt  = r_cycle_cnt;
  assign RetireCnt = r_retire_cnt;
  assign StallCnt  = r_stall_cnt;
`endif
endmodule
